sb_tx_arbiter: RTL

- Arbitrates the single sideband transmit path (byte serializer driving sbtx) among three frame sources: LT (link-training transactions), ATR (AT responses), ATC (AT commands).
- Grants one requester at a time and streams its bytes to the serializer using valid/ready.
- Enforces a minimum idle gap between frames and aborts stalled or oversized frames.
- Sits between the link-training FSM / AT engine and the sideband serializer in the sb_clk domain.

---
 rtl/sb_tx_arbiter_if.sv | 51 +++++
 rtl/sb_tx_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sb_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// sb_tx_arbiter_if
//
// Bundles the frame-source handshake and the serializer handshake of the
// sideband transmit arbiter.
//
//   req       [2:0]   per-source frame request (0 = LT, 1 = ATR, 2 = ATC)
//   in_data   [23:0]  per-source byte, bits [8i+7:8i] belong to source i
//   in_valid  [2:0]   per-source byte valid
//   in_last   [2:0]   per-source last-byte flag
//   in_ready  [2:0]   per-source byte accepted (only the granted bit)
//   gnt       [2:0]   one-hot registered grant
//   ser_data  [7:0]   byte to serializer
//   ser_valid         byte valid to serializer
//   ser_last          final byte of frame
//   ser_ready         serializer accepts byte
//   ser_abort         one-cycle pulse, serializer discards partial frame
//   abort_id  [1:0]   index of the aborted source, valid with ser_abort
//   busy              arbiter not idle
//
// Modports:
//   master : the frame sources plus the serializer (drives requests/ready)
//   slave  : the arbiter itself
// ---------------------------------------------------------------------------
interface sb_tx_arbiter_if;
  logic [2:0]  req;
  logic [23:0] in_data;
  logic [2:0]  in_valid;
  logic [2:0]  in_last;
  logic [2:0]  in_ready;
  logic [2:0]  gnt;
  logic [7:0]  ser_data;
  logic        ser_valid;
  logic        ser_last;
  logic        ser_ready;
  logic        ser_abort;
  logic [1:0]  abort_id;
  logic        busy;

  modport master (
    output req, in_data, in_valid, in_last, ser_ready,
    input  in_ready, gnt, ser_data, ser_valid, ser_last, ser_abort,
           abort_id, busy
  );

  modport slave (
    input  req, in_data, in_valid, in_last, ser_ready,
    output in_ready, gnt, ser_data, ser_valid, ser_last, ser_abort,
           abort_id, busy
  );
endinterface

// File: rtl/sb_tx_arbiter.sv
// ---------------------------------------------------------------------------
// sb_tx_arbiter
//
// Shares the single sideband transmit serializer among three frame sources:
// LT (link training, index 0), ATR (AT responses, index 1) and ATC
// (AT commands, index 2). One source is granted at a time and its bytes are
// passed combinationally to the serializer over valid/ready. After every
// frame end or abort a fixed idle gap is enforced. Frames are aborted when
// the granted source drops its request mid-frame, stalls for TIMEOUT cycles,
// or exceeds MAX_BYTES without a last byte.
//
// Ports:
//   sb_clk  sideband clock, the only clock
//   rst     asynchronous active-low reset
//   sb      sb_tx_arbiter_if.slave, all handshake/data signals
//
// Parameters:
//   N_REQ       number of requesters, fixed at 3
//   MAX_BYTES   maximum bytes per frame including the last byte
//   GAP_CYCLES  idle cycles after every frame end or abort (0 is legal)
//   TIMEOUT     consecutive in_valid-low XFER cycles before an abort
//
// Build option:
//   SB_ARB_RR_EN  when defined, ATR and ATC alternate via a round-robin
//                 pointer (LT still has absolute priority). When undefined,
//                 selection is fixed priority LT > ATR > ATC.
// ---------------------------------------------------------------------------
module sb_tx_arbiter #(
  parameter int N_REQ      = 3,
  parameter int MAX_BYTES  = 16,
  parameter int GAP_CYCLES = 10,
  parameter int TIMEOUT    = 64
) (
  input logic            sb_clk,
  input logic            rst,
  sb_tx_arbiter_if.slave sb
);

  localparam int BYTE_W = $clog2(MAX_BYTES + 1);
  localparam int TO_W   = $clog2(TIMEOUT + 1);
  localparam int GAP_W  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(MAX_BYTES - 1);
  localparam logic [BYTE_W-1:0] BYTE_MAX  = BYTE_W'(MAX_BYTES);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0]   TO_MAX    = TO_W'(TIMEOUT);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  state_e             state_r, state_s;
  logic [N_REQ-1:0]   gnt_r, gnt_s;
  logic [1:0]         gidx_r, gidx_s;
  logic [BYTE_W-1:0]  byte_cnt_r, byte_cnt_s;
  logic [TO_W-1:0]    to_cnt_r, to_cnt_s;
  logic [GAP_W-1:0]   gap_cnt_r, gap_cnt_s;
  logic               ser_abort_r, ser_abort_s;
  logic [1:0]         abort_id_r, abort_id_s;

  logic [1:0]         win_idx_s;
  logic [N_REQ-1:0]   win_vec_s;

  logic [7:0]         ser_data_s;
  logic               ser_valid_s;
  logic               ser_last_s;
  logic               req_g_s;
  logic [N_REQ-1:0]   in_ready_s;

  logic               xfer_s;
  logic               last_xfer_s;
  logic               abort_drop_s;
  logic               abort_to_s;
  logic               abort_ovf_s;
  logic               abort_s;

`ifdef SB_ARB_RR_EN
  // 1 = ATC is favoured on the next ATR/ATC contention, 0 = ATR is favoured.
  logic               rr_fav_atc_r;

  // Round-robin pointer: after granting one of ATR/ATC, favour the other.
  always_ff @(posedge sb_clk or negedge rst) begin
    if (!rst) begin
      rr_fav_atc_r <= 1'b0;
    end else if ((state_r == ST_IDLE) && (sb.req != 3'b000)) begin
      if (win_idx_s == 2'd1) begin
        rr_fav_atc_r <= 1'b1;
      end else if (win_idx_s == 2'd2) begin
        rr_fav_atc_r <= 1'b0;
      end else begin
        rr_fav_atc_r <= rr_fav_atc_r;
      end
    end else begin
      rr_fav_atc_r <= rr_fav_atc_r;
    end
  end
`endif

  // Winner selection: LT always first, then ATR/ATC.
  always_comb begin
    win_idx_s = 2'd0;
    if (sb.req[0]) begin
      win_idx_s = 2'd0;
`ifdef SB_ARB_RR_EN
    end else if (sb.req[1] && sb.req[2]) begin
      win_idx_s = rr_fav_atc_r ? 2'd2 : 2'd1;
`endif
    end else if (sb.req[1]) begin
      win_idx_s = 2'd1;
    end else if (sb.req[2]) begin
      win_idx_s = 2'd2;
    end else begin
      win_idx_s = 2'd0;
    end
    win_vec_s = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx_s;
  end

  // Byte mux from the granted source to the serializer; all zero without a grant.
  always_comb begin
    ser_data_s  = 8'h00;
    ser_valid_s = 1'b0;
    ser_last_s  = 1'b0;
    req_g_s     = 1'b0;
    in_ready_s  = {N_REQ{1'b0}};
    if (gnt_r != {N_REQ{1'b0}}) begin
      case (gidx_r)
        2'd0: begin
          ser_data_s  = sb.in_data[7:0];
          ser_valid_s = sb.in_valid[0];
          ser_last_s  = sb.in_last[0];
          req_g_s     = sb.req[0];
        end
        2'd1: begin
          ser_data_s  = sb.in_data[15:8];
          ser_valid_s = sb.in_valid[1];
          ser_last_s  = sb.in_last[1];
          req_g_s     = sb.req[1];
        end
        2'd2: begin
          ser_data_s  = sb.in_data[23:16];
          ser_valid_s = sb.in_valid[2];
          ser_last_s  = sb.in_last[2];
          req_g_s     = sb.req[2];
        end
        default: begin
          ser_data_s  = 8'h00;
          ser_valid_s = 1'b0;
          ser_last_s  = 1'b0;
          req_g_s     = 1'b0;
        end
      endcase
      in_ready_s = gnt_r & {N_REQ{sb.ser_ready}};
    end else begin
      in_ready_s = {N_REQ{1'b0}};
    end
  end

  // Transfer detection and the three abort conditions. A normal last byte
  // masks every abort condition, so an exactly MAX_BYTES-long frame and a
  // request dropped together with the last byte both end cleanly.
  always_comb begin
    xfer_s       = ser_valid_s & sb.ser_ready;
    last_xfer_s  = xfer_s & ser_last_s;
    abort_drop_s = ~req_g_s;
    abort_to_s   = ~ser_valid_s & (to_cnt_r >= TO_LAST);
    abort_ovf_s  = xfer_s & ~ser_last_s & (byte_cnt_r >= BYTE_LAST);
    abort_s      = (abort_drop_s | abort_to_s | abort_ovf_s) & ~last_xfer_s;
  end

  // Next-state, grant, counters and abort pulse.
  always_comb begin
    state_s     = state_r;
    gnt_s       = gnt_r;
    gidx_s      = gidx_r;
    byte_cnt_s  = byte_cnt_r;
    to_cnt_s    = to_cnt_r;
    gap_cnt_s   = gap_cnt_r;
    ser_abort_s = 1'b0;
    abort_id_s  = abort_id_r;
    case (state_r)
      ST_IDLE: begin
        if (sb.req != 3'b000) begin
          state_s    = ST_XFER;
          gnt_s      = win_vec_s;
          gidx_s     = win_idx_s;
          byte_cnt_s = {BYTE_W{1'b0}};
          to_cnt_s   = {TO_W{1'b0}};
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_XFER: begin
        if (last_xfer_s || abort_s) begin
          // With no gap configured the FSM skips GAP entirely.
          state_s     = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
          gnt_s       = {N_REQ{1'b0}};
          gap_cnt_s   = {GAP_W{1'b0}};
          byte_cnt_s  = {BYTE_W{1'b0}};
          to_cnt_s    = {TO_W{1'b0}};
          ser_abort_s = abort_s;
          abort_id_s  = abort_s ? gidx_r : abort_id_r;
        end else begin
          if (xfer_s && (byte_cnt_r != BYTE_MAX)) begin
            byte_cnt_s = byte_cnt_r + 1'b1;
          end else begin
            byte_cnt_s = byte_cnt_r;
          end
          // Only cycles with in_valid low count toward the stall timeout.
          if (ser_valid_s) begin
            to_cnt_s = {TO_W{1'b0}};
          end else if (to_cnt_r != TO_MAX) begin
            to_cnt_s = to_cnt_r + 1'b1;
          end else begin
            to_cnt_s = to_cnt_r;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_r >= GAP_LAST) begin
          state_s = ST_IDLE;
        end else begin
          gap_cnt_s = gap_cnt_r + 1'b1;
        end
      end
      default: begin
        state_s = ST_IDLE;
        gnt_s   = {N_REQ{1'b0}};
      end
    endcase
  end

  // State and control registers.
  always_ff @(posedge sb_clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      gnt_r       <= {N_REQ{1'b0}};
      gidx_r      <= 2'd0;
      byte_cnt_r  <= {BYTE_W{1'b0}};
      to_cnt_r    <= {TO_W{1'b0}};
      gap_cnt_r   <= {GAP_W{1'b0}};
      ser_abort_r <= 1'b0;
      abort_id_r  <= 2'd0;
    end else begin
      state_r     <= state_s;
      gnt_r       <= gnt_s;
      gidx_r      <= gidx_s;
      byte_cnt_r  <= byte_cnt_s;
      to_cnt_r    <= to_cnt_s;
      gap_cnt_r   <= gap_cnt_s;
      ser_abort_r <= ser_abort_s;
      abort_id_r  <= abort_id_s;
    end
  end

  assign sb.gnt       = gnt_r;
  assign sb.in_ready  = in_ready_s;
  assign sb.ser_data  = ser_data_s;
  assign sb.ser_valid = ser_valid_s;
  assign sb.ser_last  = ser_last_s;
  assign sb.ser_abort = ser_abort_r;
  assign sb.abort_id  = abort_id_r;
  assign sb.busy      = (state_r != ST_IDLE);

endmodule
